pc_seq_ctrl: RTL
================

PC_SEQ_CTRL -- requirements
Module: pc_seq_ctrl

Interface
REQ-001 Parameter ADDR_W, default 32, sets the instruction address width.
REQ-002 Parameter FLUSH_CYC, default 1, sets the number of flush cycles after an issued redirect, legal range 1..3.
REQ-003 clk  input  1  clock; all state updates on the rising edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 jtag_reset_i  input  1  debug reset request, level.
REQ-006 jtag_halt_i  input  1  debug halt request, level.
REQ-007 int_req_i / int_addr_i  input  1 / ADDR_W  interrupt redirect request and target.
REQ-008 ex_jump_i / ex_addr_i  input  1 / ADDR_W  execute-stage redirect (branch, jump, mispredict) and target.
REQ-009 prdt_req_i / prdt_addr_i  input  1 / ADDR_W  predictor taken hint and target.
REQ-010 ex_hold_i  input  1  execute multi-cycle stall (div, csr).
REQ-011 bus_hold_i  input  1  fetch bus busy; no fetch redirect is accepted this cycle.
REQ-012 jump_flag_o / jump_addr_o  output  1 / ADDR_W  redirect to the PC register.
REQ-013 hold_flag_o  output  3  pipeline hold level: 0 none, 1 PC, 2 PC+IF, 3 PC+IF+ID.
REQ-014 stall_flag_o  output  1  PC freeze.
REQ-015 prdt_taken_o / prdt_addr_o  output  1 / ADDR_W  forwarded prediction.
REQ-016 pc_reset_o  output  1  PC reset strobe.
REQ-017 int_ack_o  output  1  one-cycle pulse when the interrupt redirect is issued.

Function
REQ-018 The FSM SHALL have the states RUN, PEND, FLUSH and HALT.
REQ-019 pc_reset_o SHALL equal rst OR jtag_reset_i combinationally, and jtag_reset_i SHALL force state RUN, clear the pending slot and set all other outputs to 0 in the same cycle.
REQ-020 Redirect priority SHALL be: interrupt > execute > predictor, evaluated each cycle in RUN.
REQ-021 In RUN with bus_hold_i=0 and an int or ex request, the block SHALL assert jump_flag_o=1 with the winner's address combinationally and move to FLUSH next cycle.
REQ-022 In RUN with bus_hold_i=1 and an int or ex request, the block SHALL latch the winner (address plus source bit) into the pending slot, assert stall_flag_o, and move to PEND.
REQ-023 In PEND, a newly arriving int request SHALL overwrite a pending ex entry, and a new ex request SHALL NOT overwrite a pending entry.
REQ-024 In PEND, the pending redirect SHALL be issued on the first cycle with bus_hold_i=0, followed by a move to FLUSH.
REQ-025 In FLUSH, hold_flag_o SHALL be 3 for exactly FLUSH_CYC cycles, counted by a 2-bit counter, then the state SHALL return to RUN; requests arriving during FLUSH SHALL be ignored.
REQ-026 int_ack_o SHALL pulse in the cycle the interrupt redirect drives jump_flag_o, and only then.
REQ-027 prdt_taken_o SHALL equal prdt_req_i only in RUN with no int/ex request, no hold and no halt; prdt_addr_o SHALL pass through.
REQ-028 In RUN, ex_hold_i=1 SHALL give hold_flag_o=2, and bus_hold_i=1 alone SHALL give stall_flag_o=1 with hold_flag_o=0.
REQ-029 jtag_halt_i SHALL be honoured only from RUN with no request pending: move to HALT, where hold_flag_o=3 holds until halt deasserts, then return to RUN.
REQ-030 Simultaneous int and ex requests SHALL issue only int; the ex request is dropped, because the execute stage is flushed.
REQ-031 Outputs other than jump_addr_o and prdt_addr_o SHALL be 0 whenever no condition above applies.

Reset
REQ-032 On rst the state SHALL become RUN, the counter 0, the pending slot cleared, and all outputs 0 except pc_reset_o=1.
REQ-033 rst asserted in PEND or FLUSH SHALL discard the pending redirect without issuing it.

Structure
REQ-034 The hold-level encodings (0..3), the reset address and the state encodings SHALL live in the shared defines package, reusing the existing Hold_* constants.
REQ-035 The pending slot SHALL be implemented as one sub-module, redirect_slot (valid, source, address, with overwrite rule), and the remainder SHALL be flat.

Verification
REQ-036 Test: ex_jump_i=1, ex_addr_i=0x100, bus idle -> jump_flag_o=1, addr 0x100 same cycle; hold_flag_o=3 next cycle only (FLUSH_CYC=1).
REQ-037 Test: bus_hold_i=1 for 3 cycles with ex_jump_i pulsed at 0x200 -> stall_flag_o=1 for 3 cycles, then jump_flag_o=1 with addr 0x200 on the release cycle.
REQ-038 Test: int_req_i (0x80) and ex_jump_i (0x300) in the same cycle -> only 0x80 issued, int_ack_o=1 for one cycle.
REQ-039 Test: PEND holding ex 0x300, then int 0x80 arrives -> 0x80 issued on bus release, and 0x300 is never issued.
REQ-040 Test: prdt_req_i=1 (0x40) in RUN -> prdt_taken_o=1; the same stimulus with ex_hold_i=1 -> prdt_taken_o=0, hold_flag_o=2.
REQ-041 Test: jtag_reset_i pulsed in FLUSH -> pc_reset_o=1 in the same cycle, state RUN, hold_flag_o=0 next cycle.

Source files
------------

// File: rtl/pc_seq_ctrl_pkg.sv
// Shared definitions for the PC sequencing controller: pipeline hold levels,
// the PC reset address and the sequencer state encodings.
package pc_seq_ctrl_pkg;

  localparam logic [2:0] Hold_None = 3'd0;
  localparam logic [2:0] Hold_Pc   = 3'd1;
  localparam logic [2:0] Hold_If   = 3'd2;
  localparam logic [2:0] Hold_Id   = 3'd3;

  localparam logic [31:0] ResetAddr = 32'h0000_0000;

  typedef enum logic [1:0] {
    StRun   = 2'd0,
    StPend  = 2'd1,
    StFlush = 2'd2,
    StHalt  = 2'd3
  } state_e;

endpackage

// File: rtl/pc_seq_ctrl_if.sv
// Request/response bundle between the pipeline (master) and the PC
// sequencing controller (slave).
interface pc_seq_ctrl_if
  import pc_seq_ctrl_pkg::*;
#(
  parameter int ADDR_W = 32
);

  logic              jtag_reset_i;
  logic              jtag_halt_i;
  logic              int_req_i;
  logic [ADDR_W-1:0] int_addr_i;
  logic              ex_jump_i;
  logic [ADDR_W-1:0] ex_addr_i;
  logic              prdt_req_i;
  logic [ADDR_W-1:0] prdt_addr_i;
  logic              ex_hold_i;
  logic              bus_hold_i;

  logic              jump_flag_o;
  logic [ADDR_W-1:0] jump_addr_o;
  logic [2:0]        hold_flag_o;
  logic              stall_flag_o;
  logic              prdt_taken_o;
  logic [ADDR_W-1:0] prdt_addr_o;
  logic              pc_reset_o;
  logic              int_ack_o;

  modport master (
    output jtag_reset_i, jtag_halt_i, int_req_i, int_addr_i, ex_jump_i, ex_addr_i,
           prdt_req_i, prdt_addr_i, ex_hold_i, bus_hold_i,
    input  jump_flag_o, jump_addr_o, hold_flag_o, stall_flag_o, prdt_taken_o,
           prdt_addr_o, pc_reset_o, int_ack_o
  );

  modport slave (
    input  jtag_reset_i, jtag_halt_i, int_req_i, int_addr_i, ex_jump_i, ex_addr_i,
           prdt_req_i, prdt_addr_i, ex_hold_i, bus_hold_i,
    output jump_flag_o, jump_addr_o, hold_flag_o, stall_flag_o, prdt_taken_o,
           prdt_addr_o, pc_reset_o, int_ack_o
  );

endinterface

// File: rtl/pc_seq_ctrl_redirect_slot.sv
// redirect_slot: one-entry store for a redirect the fetch bus could not take yet.
// An interrupt may replace a stored execute redirect; nothing else replaces an entry.
module pc_seq_ctrl_redirect_slot
  import pc_seq_ctrl_pkg::*;
#(
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clr_i,
  input  logic              ld_i,
  input  logic              ld_int_i,
  input  logic [ADDR_W-1:0] ld_addr_i,
  output logic              vld_o,
  output logic              int_o,
  output logic [ADDR_W-1:0] addr_o
);

  logic              vld_q, vld_d;
  logic              int_q, int_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              take;

  always_comb begin
    take   = ld_i && (!vld_q || (ld_int_i && !int_q));
    vld_d  = vld_q;
    int_d  = int_q;
    addr_d = addr_q;
    if (clr_i) begin
      vld_d  = 1'b0;
      int_d  = 1'b0;
      addr_d = ADDR_W'(ResetAddr);
    end else if (take) begin
      vld_d  = 1'b1;
      int_d  = ld_int_i;
      addr_d = ld_addr_i;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      vld_q  <= 1'b0;
      int_q  <= 1'b0;
      addr_q <= ADDR_W'(ResetAddr);
    end else begin
      vld_q  <= vld_d;
      int_q  <= int_d;
      addr_q <= addr_d;
    end
  end

  assign vld_o  = vld_q;
  assign int_o  = int_q;
  assign addr_o = addr_q;

endmodule

// File: rtl/pc_seq_ctrl.sv
// PC sequencing controller: arbitrates interrupt/execute/predictor redirects,
// parks redirects while the fetch bus is busy, and drives pipeline hold levels.
module pc_seq_ctrl
  import pc_seq_ctrl_pkg::*;
#(
  parameter int ADDR_W    = 32,
  parameter int FLUSH_CYC = 1
) (
  input logic         clk,
  input logic         rst,
  pc_seq_ctrl_if.slave ctrl
);

  localparam logic [1:0] FlushLast = 2'(FLUSH_CYC - 1);

  state_e            state_q, state_d;
  logic [1:0]        cnt_q, cnt_d;

  logic              kill;
  logic              anyReq;
  logic [ADDR_W-1:0] winAddr;
  logic              slotClr, slotLd, slotVld, slotInt;
  logic [ADDR_W-1:0] slotAddr;

  logic              jumpFlag, intAck, stallFlag, prdtTaken;
  logic [2:0]        holdFlag;
  logic [ADDR_W-1:0] jumpAddr;

  assign kill    = rst || ctrl.jtag_reset_i;
  assign anyReq  = ctrl.int_req_i || ctrl.ex_jump_i;
  assign winAddr = ctrl.int_req_i ? ctrl.int_addr_i : ctrl.ex_addr_i;

  pc_seq_ctrl_redirect_slot #(
    .ADDR_W(ADDR_W)
  ) redirect_slot (
    .clk      (clk),
    .rst      (rst),
    .clr_i    (slotClr),
    .ld_i     (slotLd),
    .ld_int_i (ctrl.int_req_i),
    .ld_addr_i(winAddr),
    .vld_o    (slotVld),
    .int_o    (slotInt),
    .addr_o   (slotAddr)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StRun;
      cnt_q   <= 2'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    slotClr   = 1'b0;
    slotLd    = 1'b0;
    jumpFlag  = 1'b0;
    jumpAddr  = '0;
    intAck    = 1'b0;
    stallFlag = 1'b0;
    holdFlag  = Hold_None;
    prdtTaken = 1'b0;

    if (kill) begin
      state_d = StRun;
      cnt_d   = 2'd0;
      slotClr = 1'b1;
    end else begin
      unique case (state_q)
        StRun: begin
          holdFlag = ctrl.ex_hold_i ? Hold_If : Hold_None;
          if (anyReq && !ctrl.bus_hold_i) begin
            jumpFlag = 1'b1;
            jumpAddr = winAddr;
            intAck   = ctrl.int_req_i;
            state_d  = StFlush;
            cnt_d    = 2'd0;
          end else if (anyReq) begin
            slotLd    = 1'b1;
            stallFlag = 1'b1;
            state_d   = StPend;
          end else begin
            stallFlag = ctrl.bus_hold_i;
            if (ctrl.jtag_halt_i) begin
              state_d = StHalt;
            end else begin
              prdtTaken = ctrl.prdt_req_i && !ctrl.ex_hold_i && !ctrl.bus_hold_i;
            end
          end
        end

        StPend: begin
          if (!slotVld) begin
            state_d = StRun;
          end else if (ctrl.bus_hold_i) begin
            stallFlag = 1'b1;
            slotLd    = anyReq;
          end else begin
            // An interrupt arriving on the release cycle still beats a parked execute redirect.
            jumpFlag = 1'b1;
            if (ctrl.int_req_i && !slotInt) begin
              jumpAddr = ctrl.int_addr_i;
              intAck   = 1'b1;
            end else begin
              jumpAddr = slotAddr;
              intAck   = slotInt;
            end
            slotClr = 1'b1;
            state_d = StFlush;
            cnt_d   = 2'd0;
          end
        end

        StFlush: begin
          holdFlag = Hold_Id;
          if (cnt_q == FlushLast) begin
            state_d = StRun;
            cnt_d   = 2'd0;
          end else begin
            cnt_d = cnt_q + 2'd1;
          end
        end

        StHalt: begin
          holdFlag = Hold_Id;
          if (!ctrl.jtag_halt_i) begin
            state_d = StRun;
          end
        end

        default: state_d = StRun;
      endcase
    end
  end

  assign ctrl.jump_flag_o  = jumpFlag;
  assign ctrl.jump_addr_o  = jumpAddr;
  assign ctrl.hold_flag_o  = holdFlag;
  assign ctrl.stall_flag_o = stallFlag;
  assign ctrl.prdt_taken_o = prdtTaken;
  assign ctrl.prdt_addr_o  = ctrl.prdt_addr_i;
  assign ctrl.pc_reset_o   = kill;
  assign ctrl.int_ack_o    = intAck;

endmodule
